matrix_streamer: RTL
====================

# matrix_streamer

Serializes a packed matrix result into a row-major element stream over a valid/ready handshake. It sits on the output side of the matrix arithmetic units: it takes the 5x5, 8-bit packed result bus plus its dimensions and hands elements one per cycle to a downstream consumer (display/UART formatter), with row/column tags and last flags. The matrix and dimensions are captured on `start`, so the producer may change its bus while streaming is in progress.

## Interface
Parameters:
- MAX_DIM, 5, maximum rows/columns
- ELEM_WIDTH, 8, bits per element; packed bus width is MAX_DIM*MAX_DIM*ELEM_WIDTH (200)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to capture and stream; sampled only in IDLE
- m  in  3  row count, valid range 1..MAX_DIM
- n  in  3  column count, valid range 1..MAX_DIM
- matrix_in  in  200  packed matrix; element (i,j) at bits [(i*MAX_DIM+j)*ELEM_WIDTH +: ELEM_WIDTH]
- elem_out  out  8  current element
- elem_valid  out  1  elem_out/row/col/flags are valid
- elem_ready  in  1  consumer accepts the element this cycle
- row  out  3  row index of elem_out
- col  out  3  column index of elem_out
- row_last  out  1  col == n-1
- mat_last  out  1  last element of the matrix (row == m-1 and col == n-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the final element is accepted
- err  out  1  one-cycle pulse when start carries invalid dimensions

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - start with m or n equal to 0 or greater than MAX_DIM -> err=1 for the next cycle, stay IDLE, nothing captured.
  - start with valid dims -> capture matrix_in, m, n; row=col=0; go to SEND.
- SEND:
  - elem_valid=1; elem_out = captured[(row*MAX_DIM+col)*ELEM_WIDTH +: ELEM_WIDTH].
  - Handshake occurs when elem_valid && elem_ready.
  - On a handshake with col < n-1: col+1.
  - On a handshake with col == n-1 and row < m-1: col=0, row+1.
  - On a handshake with row == m-1 and col == n-1: go to DONE.
  - Without a handshake, all outputs hold.
- DONE: done=1 for exactly one cycle, elem_valid=0, then go to IDLE.
- start is ignored in SEND and DONE; there is no queueing.
- Elements outside m x n are never emitted.
- All outputs come from registers or from a mux of registered state only. There is no combinational path from any input to any output.
- elem_valid never depends on elem_ready. Once elem_valid is asserted, it and the payload stay stable until the handshake.
- Index arithmetic: row and col are 3-bit and never exceed MAX_DIM-1. The element offset is computed at full width, with no truncation.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; elem_out=0, elem_valid=0, row=0, col=0, row_last=0, mat_last=0, busy=0, done=0, err=0. Captured matrix and dims are cleared to 0.
- Reset mid-stream aborts immediately. No done pulse is generated, and the block resumes in IDLE after release.
- A valid start sampled at edge t gives busy=1 and elem_valid=1 with element (0,0) after edge t.
- With elem_ready held high, one element is accepted per cycle; SEND lasts exactly m*n cycles.
- done is high in the cycle after the final handshake. busy falls one cycle later, and a new start is accepted from that IDLE cycle.
- err is high in the cycle after the invalid start, and busy stays 0.
- Latency, start to done with ready held high: m*n+1 cycles.

## Test plan
- m=2, n=3, matrix_in elements (i,j)=10*i+j, ready held high -> elem_out 0,1,2,10,11,12 on consecutive cycles. row_last on 2 and 12; mat_last on 12 only; done one cycle after 12; busy high for 7 cycles.
- m=5, n=5, elem_ready toggling 1,0,0,1... -> exactly 25 handshakes in row-major order. elem_out and elem_valid stay stable during stalls; done fires once.
- m=1, n=1, element (0,0)=0xFF -> single beat with 0xFF, row_last=mat_last=1, done next cycle.
- start with m=0, and separately with n=6 -> err pulse of one cycle, busy=0, elem_valid never asserted.
- Streaming 3x3, then pulse start with different m/n and change matrix_in mid-stream -> ignored; the original 9 captured elements are emitted unchanged.
- Drive reset=0 asynchronously mid-stream (4th element, between edges) -> all outputs 0 immediately with no done pulse. After release, a fresh 2x2 start streams correctly from (0,0).

Source files
------------

// File: rtl/matrix_streamer_if.sv
// Element stream from matrix_streamer to its consumer: payload, tags and
// flags travel with elem_valid; the consumer answers with elem_ready.
interface matrix_streamer_if #(
  parameter int ELEM_WIDTH = 8,
  parameter int IDX_W      = 3
);
  logic [ELEM_WIDTH-1:0] elem_out;
  logic                  elem_valid;
  logic                  elem_ready;
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic                  row_last;
  logic                  mat_last;

  modport master (
    output elem_out, elem_valid, row, col, row_last, mat_last,
    input  elem_ready
  );

  modport slave (
    input  elem_out, elem_valid, row, col, row_last, mat_last,
    output elem_ready
  );
endinterface

// File: rtl/matrix_streamer.sv
// Captures a packed MAX_DIM x MAX_DIM matrix on start and streams its m x n
// active elements in row-major order over a valid/ready handshake.
module matrix_streamer #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [2:0]                            m,
  input  logic [2:0]                            n,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_in,
  matrix_streamer_if.master                     strm,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int             BUS_W   = MAX_DIM * MAX_DIM * ELEM_WIDTH;
  localparam int             OFF_W   = $clog2(BUS_W);
  localparam logic [2:0]     DIM_MAX = 3'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state_q, state_d;
  logic [BUS_W-1:0]   mat_p0;
  logic [2:0]         m_p0, n_p0;
  logic [2:0]         row_p0, col_p0;
  logic               err_p0;

  logic dims_ok, take, hs, col_end, row_end, sending;

  // Offset is formed at integer width and only then narrowed to the bus index.
  function automatic logic [ELEM_WIDTH-1:0] elem_at(
    input logic [BUS_W-1:0] mat,
    input logic [2:0]       r,
    input logic [2:0]       c
  );
    logic [OFF_W-1:0] off;
    off = OFF_W'((int'(r) * MAX_DIM + int'(c)) * ELEM_WIDTH);
    return mat[off +: ELEM_WIDTH];
  endfunction

  assign dims_ok = (m != 3'd0) && (m <= DIM_MAX) && (n != 3'd0) && (n <= DIM_MAX);
  assign take    = (state_q == IDLE) && start && dims_ok;
  assign sending = (state_q == SEND);
  assign hs      = sending && strm.elem_ready;
  assign col_end = (col_p0 == n_p0 - 3'd1);
  assign row_end = (row_p0 == m_p0 - 3'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = SEND;
      SEND:    if (hs && col_end && row_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture stage: matrix, dims and the current row/col cursor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mat_p0 <= '0;
      m_p0   <= '0;
      n_p0   <= '0;
      row_p0 <= '0;
      col_p0 <= '0;
      err_p0 <= 1'b0;
    end else begin
      err_p0 <= (state_q == IDLE) && start && !dims_ok;
      if (take) begin
        mat_p0 <= matrix_in;
        m_p0   <= m;
        n_p0   <= n;
        row_p0 <= '0;
        col_p0 <= '0;
      end else if (hs) begin
        // Wrapping on the final beat leaves the cursor at (0,0) for idle.
        if (col_end) begin
          col_p0 <= '0;
          row_p0 <= row_end ? 3'd0 : row_p0 + 3'd1;
        end else begin
          col_p0 <= col_p0 + 3'd1;
        end
      end
    end
  end

  // Output stage: muxes of registered state only.
  assign strm.elem_valid = sending;
  assign strm.elem_out   = sending ? elem_at(mat_p0, row_p0, col_p0) : '0;
  assign strm.row        = row_p0;
  assign strm.col        = col_p0;
  assign strm.row_last   = sending && col_end;
  assign strm.mat_last   = sending && col_end && row_end;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign err             = err_p0;

endmodule
